csr_regfile: RTL and testbench

- Machine-mode CSR register file for the 5-stage RV32 core.
- ID stage reads it to produce csr_data_ID.
- The address, operand and op that travel down the pipeline come back at WB, where the CSRRW/CSRRS/CSRRC read-modify-write is applied.
- Also keeps the free-running cycle counter and the retired-instruction counter.

---
 rtl/csr_regfile.sv | 198 +++++++++++++++++++
 tb/tb_csr_regfile.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational ID read with WB write-through bypass, WB read-modify-write,
// 64-bit mcycle/minstret counters. Read path zero latency, writes commit on the next edge; no backpressure.
module csr_regfile #(
    parameter logic [31:0] MISA_VAL  = 32'h40000100,
    parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_rd_addr,
    output logic [31:0] csr_rd_data,
    output logic        csr_rd_illegal,
    input  logic [1:0]  csr_wb_op,
    input  logic [11:0] csr_wb_addr,
    input  logic [31:0] csr_wb_operand,
    output logic        csr_wb_illegal,
    input  logic        retire
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] wb_old;
    logic [31:0] wb_raw;
    logic [31:0] wb_new;
    logic        wb_writable;
    logic        wb_we;
    logic [31:0] rd_raw;
    logic        rd_impl;
    logic [32:0] cyc_lo_inc;
    logic [32:0] ret_lo_inc;

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
            A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH: is_writable = 1'b1;
            default:                                      is_writable = 1'b0;
        endcase
    endfunction

    function automatic logic is_impl(input logic [11:0] a);
        case (a)
            A_MISA, A_CYCLE, A_INSTRET, A_CYCLEH, A_INSTRETH: is_impl = 1'b1;
            default:                                          is_impl = is_writable(a);
        endcase
    endfunction

    function automatic logic [31:0] csr_read(
        input logic [11:0] a,
        input logic [31:0] mstatus, input logic [31:0] mie, input logic [31:0] mtvec,
        input logic [31:0] mscratch, input logic [31:0] mepc, input logic [31:0] mcause,
        input logic [31:0] mtval, input logic [31:0] mip,
        input logic [63:0] mcycle, input logic [63:0] minstret
    );
        case (a)
            A_MSTATUS:               csr_read = mstatus;
            A_MISA:                  csr_read = MISA_VAL;
            A_MIE:                   csr_read = mie;
            A_MTVEC:                 csr_read = mtvec;
            A_MSCRATCH:              csr_read = mscratch;
            A_MEPC:                  csr_read = mepc;
            A_MCAUSE:                csr_read = mcause;
            A_MTVAL:                 csr_read = mtval;
            A_MIP:                   csr_read = mip;
            A_MCYCLE, A_CYCLE:       csr_read = mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:     csr_read = mcycle[63:32];
            A_MINSTRET, A_INSTRET:   csr_read = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: csr_read = minstret[63:32];
            default:                 csr_read = 32'h0;
        endcase
    endfunction

    // WB read-modify-write, with field masks applied before commit and bypass
    always_comb begin
        wb_old = csr_read(csr_wb_addr, mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q,
                          mcause_q, mtval_q, mip_q, mcycle_q, minstret_q);
        case (csr_wb_op)
            OP_RW:   wb_raw = csr_wb_operand;
            OP_RS:   wb_raw = wb_old | csr_wb_operand;
            OP_RC:   wb_raw = wb_old & ~csr_wb_operand;
            default: wb_raw = wb_old;
        endcase
        wb_new = wb_raw;
        if (csr_wb_addr == A_MEPC)  wb_new[1:0] = 2'b00;
        if (csr_wb_addr == A_MTVEC) wb_new[1]   = 1'b0;
        wb_writable    = is_writable(csr_wb_addr);
        wb_we          = (csr_wb_op != OP_NONE) && wb_writable;
        csr_wb_illegal = (csr_wb_op != OP_NONE) && !wb_writable;
    end

    always_comb begin
        rd_raw  = csr_read(csr_rd_addr, mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q,
                           mcause_q, mtval_q, mip_q, mcycle_q, minstret_q);
        rd_impl = is_impl(csr_rd_addr);
        csr_rd_illegal = !rd_impl;
        if (wb_we && (csr_wb_addr == csr_rd_addr)) csr_rd_data = wb_new;
        else                                       csr_rd_data = rd_raw;
    end

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = mip_q;
        if (wb_we) begin
            case (csr_wb_addr)
                A_MSTATUS:  mstatus_d  = wb_new;
                A_MIE:      mie_d      = wb_new;
                A_MTVEC:    mtvec_d    = wb_new;
                A_MSCRATCH: mscratch_d = wb_new;
                A_MEPC:     mepc_d     = wb_new;
                A_MCAUSE:   mcause_d   = wb_new;
                A_MTVAL:    mtval_d    = wb_new;
                A_MIP:      mip_d      = wb_new;
                default:    ;
            endcase
        end
    end

    // A low-half write kills the carry; a high-half write discards it but the low half still counts
    always_comb begin
        cyc_lo_inc = {1'b0, mcycle_q[31:0]} + 33'd1;
        ret_lo_inc = {1'b0, minstret_q[31:0]} + {32'b0, retire};

        mcycle_d = {mcycle_q[63:32] + {31'b0, cyc_lo_inc[32]}, cyc_lo_inc[31:0]};
        if (wb_we && csr_wb_addr == A_MCYCLE)
            mcycle_d = {mcycle_q[63:32], wb_new};
        else if (wb_we && csr_wb_addr == A_MCYCLEH)
            mcycle_d = {wb_new, cyc_lo_inc[31:0]};

        minstret_d = {minstret_q[63:32] + {31'b0, ret_lo_inc[32]}, ret_lo_inc[31:0]};
        if (wb_we && csr_wb_addr == A_MINSTRET)
            minstret_d = {minstret_q[63:32], wb_new};
        else if (wb_we && csr_wb_addr == A_MINSTRETH)
            minstret_d = {wb_new, ret_lo_inc[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= 32'h0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mip_q      <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, RMW ops, masks, bypass, illegal targets, counters, async reset.
module tb_csr_regfile;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_rd_illegal;
    logic [1:0]  csr_wb_op;
    logic [11:0] csr_wb_addr;
    logic [31:0] csr_wb_operand;
    logic        csr_wb_illegal;
    logic        retire;

    int n_cmp;
    int n_err;

    csr_regfile dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_rd_addr    (csr_rd_addr),
        .csr_rd_data    (csr_rd_data),
        .csr_rd_illegal (csr_rd_illegal),
        .csr_wb_op      (csr_wb_op),
        .csr_wb_addr    (csr_wb_addr),
        .csr_wb_operand (csr_wb_operand),
        .csr_wb_illegal (csr_wb_illegal),
        .retire         (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge, well clear of the next edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] opnd);
        csr_wb_op      = op;
        csr_wb_addr    = addr;
        csr_wb_operand = opnd;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_rd_addr = addr;
        #1;
        check(tag, csr_rd_data, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        retire = 1'b0;
        csr_rd_addr = 12'h000;
        wb(2'b00, 12'h000, 32'h0);

        tick();
        rd_check("rst_mtvec", 12'h305, 32'h00000000);
        rd_check("rst_misa", 12'h301, 32'h40000100);
        rd_check("rst_mscratch", 12'h340, 32'h00000000);
        rd_check("unimpl_data", 12'h7C0, 32'h00000000);
        check("unimpl_illegal", {31'b0, csr_rd_illegal}, 32'd1);
        check("idle_wb_illegal", {31'b0, csr_wb_illegal}, 32'd0);
        tick();
        rst_n = 1'b1;

        // mscratch RW / RS / RC, each visible through the bypass the same cycle
        wb(2'b01, 12'h340, 32'hDEADBEEF);
        rd_check("msc_rw_bypass", 12'h340, 32'hDEADBEEF);
        check("msc_rd_legal", {31'b0, csr_rd_illegal}, 32'd0);
        tick();
        wb(2'b10, 12'h340, 32'h00000010);
        rd_check("msc_rs_bypass", 12'h340, 32'hDEADBEFF);
        tick();
        wb(2'b00, 12'h340, 32'h0);
        rd_check("msc_rs", 12'h340, 32'hDEADBEFF);
        wb(2'b11, 12'h340, 32'hDEAD0000);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("msc_rc", 12'h340, 32'h0000BEFF);
        wb(2'b10, 12'h340, 32'h0);
        rd_check("msc_rs0_bypass", 12'h340, 32'h0000BEFF);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("msc_rs0", 12'h340, 32'h0000BEFF);

        // mepc low bits masked, also on the bypass path
        wb(2'b01, 12'h341, 32'h12345677);
        rd_check("mepc_bypass", 12'h341, 32'h12345674);
        check("mepc_wb_legal", {31'b0, csr_wb_illegal}, 32'd0);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("mepc_stored", 12'h341, 32'h12345674);

        wb(2'b01, 12'h305, 32'h00000103);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("mtvec_mask", 12'h305, 32'h00000101);

        // read-only and unimplemented write targets
        wb(2'b01, 12'h301, 32'h12345678);
        #1;
        check("misa_wb_illegal", {31'b0, csr_wb_illegal}, 32'd1);
        rd_check("misa_no_bypass", 12'h301, 32'h40000100);
        tick();
        wb(2'b10, 12'h7C0, 32'h1);
        #1;
        check("unimpl_wb_illegal", {31'b0, csr_wb_illegal}, 32'd1);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("misa_kept", 12'h301, 32'h40000100);

        // mcycleh=0, then mcycle=FFFFFFFF, then one increment carries into the high word
        wb(2'b01, 12'hB80, 32'h0);
        tick();
        wb(2'b01, 12'hB00, 32'hFFFFFFFF);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("mcycle_preedge", 12'hB00, 32'hFFFFFFFF);
        rd_check("mcycleh_nocarry", 12'hB80, 32'h00000000);
        tick();
        rd_check("mcycle_wrap", 12'hB00, 32'h00000000);
        rd_check("mcycleh_carry", 12'hB80, 32'h00000001);
        rd_check("cycleh_mirror", 12'hC80, 32'h00000001);
        wb(2'b01, 12'hC00, 32'h5);
        rd_check("cycle_no_bypass", 12'hC00, 32'h00000000);
        check("cycle_wb_illegal", {31'b0, csr_wb_illegal}, 32'd1);
        tick();
        wb(2'b00, 12'h000, 32'h0);
        rd_check("cycle_counts", 12'hC00, 32'h00000001);

        // retire pattern 1,1,1,0,1,1,1,1 -> 7
        retire = 1'b1; tick();
        retire = 1'b1; tick();
        retire = 1'b1; tick();
        retire = 1'b0; tick();
        retire = 1'b1; tick();
        retire = 1'b1; tick();
        retire = 1'b1; tick();
        retire = 1'b1; tick();
        retire = 1'b0;
        rd_check("minstret_7", 12'hB02, 32'd7);
        rd_check("instret_mirror", 12'hC02, 32'd7);
        rd_check("minstreth_0", 12'hB82, 32'd0);
        retire = 1'b1;
        wb(2'b01, 12'hB02, 32'd100);
        tick();
        retire = 1'b0;
        wb(2'b00, 12'h000, 32'h0);
        rd_check("minstret_write_wins", 12'hB02, 32'd100);

        // async reset between edges while an mtvec write is presented
        wb(2'b01, 12'h305, 32'h00000200);
        #1;
        rst_n = 1'b0;
        #1;
        wb(2'b00, 12'h000, 32'h0);
        rd_check("arst_mtvec", 12'h305, 32'h00000000);
        rd_check("arst_mcycle", 12'hB00, 32'h00000000);
        rd_check("arst_mcycleh", 12'hB80, 32'h00000000);
        rd_check("arst_minstret", 12'hB02, 32'h00000000);
        rd_check("arst_mscratch", 12'h340, 32'h00000000);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rd_check("post_rst_mcycle", 12'hB00, 32'd3);
        rd_check("post_rst_mtvec", 12'h305, 32'h00000000);
        rd_check("post_rst_mepc", 12'h341, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
